// File: rtl/icache_responder_if.sv
// Fetcher-side and memory-controller-side signals of the instruction cache.
// The slave view belongs to the cache; the master view drives it.
interface icache_responder_if;
    logic        IF_pc_sgn;
    logic [31:0] IF_pc;
    logic        IF_ins_sgn;
    logic [31:0] IF_ins;
    logic        ALU_sgn;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_done;
    logic [31:0] MC_data;

    modport slave (
        input  IF_pc_sgn, IF_pc, ALU_sgn, MC_done, MC_data,
        output IF_ins_sgn, IF_ins, MC_req, MC_addr
    );

    modport master (
        output IF_pc_sgn, IF_pc, ALU_sgn, MC_done, MC_data,
        input  IF_ins_sgn, IF_ins, MC_req, MC_addr
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: single-cycle hits, four-beat line refill on a miss,
// and a drop flag so a redirect cancels any response still owed without aborting the refill.
module icache_responder #(
    parameter int INDEX_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    icache_responder_if.slave   bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - 4 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_e;

    state_e                state_q, state_d;
    logic [31:2]           req_pc_q, req_pc_d;
    logic [1:0]            beat_q, beat_d;
    logic                  drop_q, drop_d;
    logic                  ins_sgn_q, ins_sgn_d;
    logic [31:0]           ins_q, ins_d;
    logic                  mc_req_q, mc_req_d;
    logic [31:0]           mc_addr_q, mc_addr_d;
    logic [LINES-1:0]      valid_q, valid_d;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES][4];

    logic [INDEX_BITS-1:0] lk_idx, fill_idx;
    logic [TAG_BITS-1:0]   lk_tag, fill_tag;
    logic                  lk_hit;
    logic [31:0]           lk_word;
    logic                  data_we, tag_we;
    logic                  unused_pc_bits;

    // Lookup uses the live request address so a hit answers on the very next edge.
    assign lk_idx   = bus.IF_pc[4+INDEX_BITS-1:4];
    assign lk_tag   = bus.IF_pc[31:4+INDEX_BITS];
    assign lk_hit   = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lk_word  = data_mem[lk_idx][bus.IF_pc[3:2]];
    assign fill_idx = req_pc_q[4+INDEX_BITS-1:4];
    assign fill_tag = req_pc_q[31:4+INDEX_BITS];
    assign unused_pc_bits = ^bus.IF_pc[1:0];

    always_comb begin
        state_d   = state_q;
        req_pc_d  = req_pc_q;
        beat_d    = beat_q;
        drop_d    = drop_q;
        ins_sgn_d = 1'b0;
        ins_d     = ins_q;
        mc_req_d  = mc_req_q;
        mc_addr_d = mc_addr_q;
        valid_d   = valid_q;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.IF_pc_sgn && !bus.ALU_sgn) begin
                    req_pc_d = bus.IF_pc[31:2];
                    if (lk_hit) begin
                        ins_sgn_d = 1'b1;
                        ins_d     = lk_word;
                    end else begin
                        state_d   = REFILL;
                        beat_d    = 2'd0;
                        mc_req_d  = 1'b1;
                        mc_addr_d = {bus.IF_pc[31:4], 4'b0000};
                        drop_d    = 1'b0;
                    end
                end
            end
            REFILL: begin
                if (bus.ALU_sgn) drop_d = 1'b1;
                if (bus.MC_done) begin
                    data_we = 1'b1;
                    if (beat_q != 2'd3) begin
                        // Only the word-offset bits advance; the line base never carries.
                        beat_d         = beat_q + 2'd1;
                        mc_addr_d[3:2] = beat_q + 2'd1;
                    end else begin
                        mc_req_d          = 1'b0;
                        valid_d[fill_idx] = 1'b1;
                        tag_we            = 1'b1;
                        state_d           = RESP;
                    end
                end
            end
            RESP: begin
                if (!drop_q && !bus.ALU_sgn) begin
                    ins_sgn_d = 1'b1;
                    ins_d     = data_mem[fill_idx][req_pc_q[3:2]];
                end
                if (bus.ALU_sgn) drop_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            req_pc_q  <= '0;
            beat_q    <= 2'd0;
            drop_q    <= 1'b0;
            ins_sgn_q <= 1'b0;
            ins_q     <= '0;
            mc_req_q  <= 1'b0;
            mc_addr_q <= '0;
            valid_q   <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            beat_q    <= beat_d;
            drop_q    <= drop_d;
            ins_sgn_q <= ins_sgn_d;
            ins_q     <= ins_d;
            mc_req_q  <= mc_req_d;
            mc_addr_q <= mc_addr_d;
            valid_q   <= valid_d;
        end
    end

    // Storage arrays carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (rdy && data_we) data_mem[fill_idx][beat_q] <= bus.MC_data;
        if (rdy && tag_we)  tag_mem[fill_idx]          <= fill_tag;
    end

    assign bus.IF_ins_sgn = ins_sgn_q;
    assign bus.IF_ins     = ins_q;
    assign bus.MC_req     = mc_req_q;
    assign bus.MC_addr    = mc_addr_q;
endmodule
